// File: rtl/pe_seq_pkg.sv
// Shared types and defaults for the PE array phase sequencer.
package pe_seq_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 17;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_MAX_K  = 7;

   localparam logic [2:0] PHASE_IDLE    = 3'd0;
   localparam logic [2:0] PHASE_LOAD_W  = 3'd1;
   localparam logic [2:0] PHASE_COMPUTE = 3'd2;
   localparam logic [2:0] PHASE_DRAIN   = 3'd3;
   localparam logic [2:0] PHASE_DONE    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = PHASE_IDLE,
      ST_LOAD_W  = PHASE_LOAD_W,
      ST_COMPUTE = PHASE_COMPUTE,
      ST_DRAIN   = PHASE_DRAIN,
      ST_DONE    = PHASE_DONE
   } state_t;

endpackage

// File: rtl/pe_seq_beat_counter.sv
// Loadable beat down-counter shared by all sequencer phases; load wins over decrement.
module pe_seq_beat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && (count != '0))
         count <= count - CNT_W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pe_array_sequencer.sv
// Phase sequencer for the systolic PE array: weight load, activation feed, skew drain.
// Define PE_SEQ_TSV_LOAD_EN to take weights from the tsv_w_* port instead of w_*.
module pe_array_sequencer
   import pe_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int MAX_K  = DEF_MAX_K
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        cfg_k,
   input  logic [CNT_W-1:0]  cfg_rows,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              w_valid,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_ready,
`ifdef PE_SEQ_TSV_LOAD_EN
   input  logic              tsv_w_valid,
   input  logic [DATA_W-1:0] tsv_w_data,
   output logic              tsv_w_ready,
`endif
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   output logic              workstate,
   output logic [DATA_W-1:0] array_w,
   output logic              array_w_vld,
   output logic [DATA_W-1:0] array_a,
   output logic              array_a_vld,
   input  logic [ACC_W-1:0]  array_psum,
   input  logic              array_psum_vld,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_valid,
   output logic [2:0]        phase
);

   state_t            state;
   logic [3:0]        k_q;
   logic [CNT_W-1:0]  rk_q;
   logic              rows_zero_q;
   logic [7:0]        kk;
   logic [CNT_W+3:0]  rk_full;
   logic              cfg_ok;
   logic              w_hs, a_hs, in_window;
   logic [DATA_W-1:0] w_src;
   logic [CNT_W-1:0]  drain_len, cnt_val, cnt;
   logic              cnt_load, cnt_dec, cnt_zero;

   // RK is formed 4 bits wider so an overflow of the beat counter is visible.
   assign kk      = {4'b0, cfg_k} * {4'b0, cfg_k};
   assign rk_full = {4'b0, cfg_rows} * (CNT_W+4)'(cfg_k);
   assign cfg_ok  = (cfg_k != 4'd0) && (int'(cfg_k) <= MAX_K) && (rk_full[CNT_W+3:CNT_W] == 4'd0);

`ifdef PE_SEQ_TSV_LOAD_EN
   logic unused_w;
   assign unused_w    = ^{w_valid, w_data};
   assign w_ready     = 1'b0;
   assign tsv_w_ready = (state == ST_LOAD_W);
   assign w_hs        = tsv_w_valid && tsv_w_ready;
   assign w_src       = tsv_w_data;
`else
   assign w_ready = (state == ST_LOAD_W);
   assign w_hs    = w_valid && w_ready;
   assign w_src   = w_data;
`endif

   assign a_ready   = (state == ST_COMPUTE);
   assign a_hs      = a_valid && a_ready;
   assign in_window = (state == ST_COMPUTE) || (state == ST_DRAIN);
   assign drain_len = CNT_W'({k_q, 1'b0}) - CNT_W'(2);
   assign phase     = state;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_load = start && cfg_ok;
            cnt_val  = CNT_W'(kk) - CNT_W'(1);
         end
         ST_LOAD_W: begin
            cnt_dec  = w_hs;
            cnt_load = w_hs && cnt_zero;
            cnt_val  = rows_zero_q ? drain_len : rk_q - CNT_W'(1);
         end
         ST_COMPUTE: begin
            cnt_dec  = a_hs;
            cnt_load = a_hs && cnt_zero;
            cnt_val  = drain_len;
         end
         ST_DRAIN: cnt_dec = 1'b1;
         default: ;
      endcase
   end

   pe_seq_beat_counter #(.CNT_W(CNT_W)) u_beat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         k_q         <= '0;
         rk_q        <= '0;
         rows_zero_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         workstate   <= 1'b0;
         array_w     <= '0;
         array_w_vld <= 1'b0;
         array_a     <= '0;
         array_a_vld <= 1'b0;
         res_data    <= '0;
         res_valid   <= 1'b0;
      end else begin
         array_w_vld <= w_hs;
         array_a_vld <= a_hs;
         res_valid   <= in_window && array_psum_vld;
         done        <= 1'b0;
         if (w_hs)
            array_w <= w_src;
         if (a_hs)
            array_a <= a_data;
         if (in_window && array_psum_vld)
            res_data <= array_psum;

         case (state)
            ST_IDLE: begin
               if (start && cfg_ok) begin
                  err         <= 1'b0;
                  k_q         <= cfg_k;
                  rk_q        <= rk_full[CNT_W-1:0];
                  rows_zero_q <= (cfg_rows == '0);
                  busy        <= 1'b1;
                  workstate   <= 1'b1;
                  state       <= ST_LOAD_W;
               end else if (start) begin
                  err  <= 1'b1;
                  done <= 1'b1;
               end
            end
            ST_LOAD_W:
               if (w_hs && cnt_zero)
                  state <= rows_zero_q ? ST_DRAIN : ST_COMPUTE;
            ST_COMPUTE:
               if (a_hs && cnt_zero)
                  state <= ST_DRAIN;
            ST_DRAIN:
               if (cnt_zero) begin
                  workstate <= 1'b0;
                  done      <= 1'b1;
                  state     <= ST_DONE;
               end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Randomized self-checking bench for pe_array_sequencer against a job-level phase model.
module tb_pe_array_sequencer;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 17;
   localparam int CNT_W  = 16;
   localparam int MAX_K  = 7;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [3:0]        cfg_k;
   logic [CNT_W-1:0]  cfg_rows;
   logic              busy, done, err;
   logic              w_valid, w_ready;
   logic [DATA_W-1:0] w_data;
`ifdef PE_SEQ_TSV_LOAD_EN
   logic              tsv_w_valid, tsv_w_ready;
   logic [DATA_W-1:0] tsv_w_data;
`endif
   logic              a_valid, a_ready;
   logic [DATA_W-1:0] a_data;
   logic              workstate;
   logic [DATA_W-1:0] array_w, array_a;
   logic              array_w_vld, array_a_vld;
   logic [ACC_W-1:0]  array_psum, res_data;
   logic              array_psum_vld, res_valid;
   logic [2:0]        phase;
   logic [63:0]       all_out;

   always #5 clk = ~clk;

   pe_array_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .MAX_K(MAX_K)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .cfg_rows(cfg_rows),
      .busy(busy), .done(done), .err(err),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
`ifdef PE_SEQ_TSV_LOAD_EN
      .tsv_w_valid(tsv_w_valid), .tsv_w_data(tsv_w_data), .tsv_w_ready(tsv_w_ready),
`endif
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready), .workstate(workstate),
      .array_w(array_w), .array_w_vld(array_w_vld), .array_a(array_a), .array_a_vld(array_a_vld),
      .array_psum(array_psum), .array_psum_vld(array_psum_vld),
      .res_data(res_data), .res_valid(res_valid), .phase(phase)
   );

`ifdef PE_SEQ_TSV_LOAD_EN
   assign all_out = 64'({tsv_w_ready, busy, done, err, w_ready, a_ready, workstate, array_w, array_w_vld,
                         array_a, array_a_vld, res_data, res_valid, phase});
`else
   assign all_out = 64'({busy, done, err, w_ready, a_ready, workstate, array_w, array_w_vld,
                         array_a, array_a_vld, res_data, res_valid, phase});
`endif

   int   total = 0;
   int   bad   = 0;
   int   m_phase, m_k, m_r, m_left;
   logic m_err;
   int   cyc, stat_w, stat_a, stat_drain, stat_busy;
   logic tog;

   // Stall-free job length from the start cycle through the done cycle.
   function automatic int job_len(input int k, input int r);
      return 1 + k * k + r * k + (2 * k - 1) + 1;
   endfunction

   task automatic drive(input int wm, input int am);
      logic wv;
      w_data         = DATA_W'($urandom);
      a_data         = DATA_W'($urandom);
      array_psum     = ACC_W'($urandom);
      array_psum_vld = 1'($urandom_range(0, 1));
      if (wm == 0) wv = 1'b1;
      else if (wm == 1 && m_phase == 1) begin wv = tog; tog = ~tog; end
      else wv = 1'($urandom_range(0, 1));
`ifdef PE_SEQ_TSV_LOAD_EN
      tsv_w_valid = wv;
      tsv_w_data  = DATA_W'($urandom);
      w_valid     = 1'($urandom_range(0, 1));
`else
      w_valid = wv;
`endif
      a_valid = (am == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   endtask

   // Advance model and DUT one clock, then compare every output against the model.
   task automatic tick();
      int ph;
      bit hs_w, hs_a, exp_done, exp_rv, exp_wr;
      logic [DATA_W-1:0] exp_w, exp_a;
      logic [ACC_W-1:0]  exp_rd;
      logic [12:0]       exp_ctrl, act_ctrl;
      ph = m_phase;
`ifdef PE_SEQ_TSV_LOAD_EN
      hs_w = (ph == 1) && tsv_w_valid;
      exp_w = tsv_w_data;
`else
      hs_w = (ph == 1) && w_valid;
      exp_w = w_data;
`endif
      hs_a     = (ph == 2) && a_valid;
      exp_a    = a_data;
      exp_rv   = (ph == 2 || ph == 3) && array_psum_vld;
      exp_rd   = array_psum;
      exp_done = 1'b0;
      case (ph)
         0: if (start) begin
               if (cfg_k == 0 || int'(cfg_k) > MAX_K || int'(cfg_rows) * int'(cfg_k) > (1 << CNT_W) - 1) begin
                  m_err = 1'b1; exp_done = 1'b1;
               end else begin
                  m_err = 1'b0; m_k = int'(cfg_k); m_r = int'(cfg_rows);
                  m_left = m_k * m_k; m_phase = 1;
               end
            end
         1: if (hs_w) begin
               m_left--;
               if (m_left == 0) begin
                  if (m_r == 0) begin m_phase = 3; m_left = 2 * m_k - 1; end
                  else begin m_phase = 2; m_left = m_r * m_k; end
               end
            end
         2: if (hs_a) begin
               m_left--;
               if (m_left == 0) begin m_phase = 3; m_left = 2 * m_k - 1; end
            end
         3: begin
               m_left--;
               if (m_left == 0) begin m_phase = 4; exp_done = 1'b1; end
            end
         default: m_phase = 0;
      endcase
`ifdef PE_SEQ_TSV_LOAD_EN
      exp_wr = 1'b0;
`else
      exp_wr = (m_phase == 1);
`endif
      @(posedge clk); #1;
      cyc++;
      stat_w     += int'(array_w_vld);
      stat_a     += int'(array_a_vld);
      stat_drain += int'(phase == 3'd3);
      stat_busy  += int'(busy);
      exp_ctrl = {3'(m_phase), m_phase != 0, m_phase >= 1 && m_phase <= 3, exp_done, m_err,
                  exp_wr, m_phase == 2, hs_w, hs_a, exp_rv};
      act_ctrl = {phase, busy, workstate, done, err, w_ready, a_ready, array_w_vld, array_a_vld, res_valid};
      total++;
      if (act_ctrl !== exp_ctrl) begin
         bad++;
         $display("FAIL ctrl t=%0t {phase,busy,ws,done,err,wr,ar,wv,av,rv} got=%b want=%b", $time, act_ctrl, exp_ctrl);
      end
      if (hs_w) begin
         total++;
         if (array_w !== exp_w) begin bad++; $display("FAIL array_w t=%0t got=%h want=%h", $time, array_w, exp_w); end
      end
      if (hs_a) begin
         total++;
         if (array_a !== exp_a) begin bad++; $display("FAIL array_a t=%0t got=%h want=%h", $time, array_a, exp_a); end
      end
      if (exp_rv) begin
         total++;
         if (res_data !== exp_rd) begin bad++; $display("FAIL res_data t=%0t got=%h want=%h", $time, res_data, exp_rd); end
      end
   endtask

   task automatic run_job(input int k, input int r, input int wm, input int am, input bit sid, output int cycles);
      int budget;
      bit seen;
      start = 1'b0;
      drive(wm, am);
      tick();
      cfg_k = 4'(k); cfg_rows = CNT_W'(r); start = 1'b1; tog = 1'b1;
      drive(wm, am);
      stat_w = 0; stat_a = 0; stat_drain = 0; stat_busy = 0;
      cyc = 1; seen = 1'b0; cycles = -1; budget = 3000;
      tick();
      while (!seen && budget > 0) begin
         if (done) begin
            seen = 1'b1; cycles = cyc;
         end else begin
            if (sid && m_phase == 3) begin start = 1'b1; cfg_k = 4'd2; cfg_rows = CNT_W'(1); end
            else begin start = 1'b0; cfg_k = 4'($urandom); cfg_rows = CNT_W'($urandom); end
            drive(wm, am);
            tick();
            budget--;
         end
      end
      start = 1'b0;
      if (!seen) begin
         total++; bad++;
         $display("FAIL job_timeout k=%0d r=%0d got=no_done want=done", k, r);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; cfg_k = '0; cfg_rows = '0;
      w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
      array_psum = '0; array_psum_vld = 1'b0;
`ifdef PE_SEQ_TSV_LOAD_EN
      tsv_w_valid = 1'b0; tsv_w_data = '0;
`endif
      m_phase = 0; m_err = 1'b0; m_k = 0; m_r = 0; m_left = 0; tog = 1'b1;
      #12;
      total++;
      if (all_out !== 64'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_nominal();
      int c;
      run_job(3, 4, 0, 0, 0, c);
      total++; if (c !== 28) begin bad++; $display("FAIL nominal_len got=%0d want=28", c); end
      total++; if (stat_w !== 9) begin bad++; $display("FAIL nominal_w_beats got=%0d want=9", stat_w); end
      total++; if (stat_a !== 12) begin bad++; $display("FAIL nominal_a_beats got=%0d want=12", stat_a); end
      total++; if (stat_drain !== 5) begin bad++; $display("FAIL nominal_drain got=%0d want=5", stat_drain); end
   endtask

   task automatic test_weight_stall();
      int c;
      run_job(3, 4, 1, 0, 0, c);
      total++; if (c !== job_len(3, 4) + 8) begin bad++; $display("FAIL wstall_len got=%0d want=%0d", c, job_len(3, 4) + 8); end
      total++; if (stat_w !== 9) begin bad++; $display("FAIL wstall_w_beats got=%0d want=9", stat_w); end
   endtask

   task automatic test_bad_config();
      int c;
      int bad_k[3] = '{0, 8, 7};
      int bad_r[3] = '{3, 5, 10000};
      for (int i = 0; i < 3; i++) begin
         run_job(bad_k[i], bad_r[i], 2, 2, 0, c);
         total++; if (c !== 2) begin bad++; $display("FAIL bad_cfg_done k=%0d got=%0d want=2", bad_k[i], c); end
         total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_cfg_err k=%0d got=%b want=1", bad_k[i], err); end
         drive(2, 2); tick(); drive(2, 2); tick();
         total++; if (stat_busy !== 0) begin bad++; $display("FAIL bad_cfg_busy k=%0d got=%0d want=0", bad_k[i], stat_busy); end
      end
      run_job(1, 2, 0, 0, 0, c);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
      total++; if (c !== job_len(1, 2)) begin bad++; $display("FAIL err_clear_len got=%0d want=%0d", c, job_len(1, 2)); end
   endtask

   task automatic test_reset_mid_job();
      int c, budget;
      cfg_k = 4'd3; cfg_rows = CNT_W'(4); start = 1'b1;
      drive(0, 0); tick();
      start = 1'b0; budget = 100;
      while (m_phase != 2 && budget > 0) begin drive(0, 0); tick(); budget--; end
      repeat (3) begin drive(0, 0); tick(); end
      #2 reset = 1'b1;
      #1;
      total++;
      if (all_out !== 64'd0) begin bad++; $display("FAIL reset_mid_job got=%h want=0", all_out); end
      m_phase = 0; m_err = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      run_job(2, 1, 0, 0, 0, c);
      total++; if (c !== 11) begin bad++; $display("FAIL post_reset_len got=%0d want=11", c); end
   endtask

   task automatic test_rows_zero();
      int c;
      run_job(2, 0, 0, 2, 1, c);
      total++; if (stat_a !== 0) begin bad++; $display("FAIL r0_a_beats got=%0d want=0", stat_a); end
      total++; if (c !== job_len(2, 0)) begin bad++; $display("FAIL r0_len got=%0d want=%0d", c, job_len(2, 0)); end
   endtask

   task automatic test_random_jobs();
      int c, k, r, ew;
      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(0, 8);
         r = $urandom_range(0, 5);
         run_job(k, r, 2, 2, 1'($urandom_range(0, 1)), c);
         ew = (k >= 1 && k <= MAX_K) ? k * k : 0;
         total++; if (stat_w !== ew) begin bad++; $display("FAIL rand_w_beats k=%0d got=%0d want=%0d", k, stat_w, ew); end
      end
   endtask

`ifdef PE_SEQ_TSV_LOAD_EN
   task automatic test_tsv_load();
      int c;
      run_job(2, 2, 2, 0, 0, c);
      total++; if (stat_w !== 4) begin bad++; $display("FAIL tsv_w_beats got=%0d want=4", stat_w); end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_weight_stall();
      test_bad_config();
      test_reset_mid_job();
      test_rows_zero();
      test_random_jobs();
`ifdef PE_SEQ_TSV_LOAD_EN
      test_tsv_load();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Phase sequencer for the systolic PE array. It accepts a job (kernel size, activation row count), streams the weights into the array, and feeds activations with flow control. It then waits out the array skew, forwards partial-sum results, and reports completion. It sits between the DMA/stream front end and the PE grid, and owns the grid's `workstate` line.

## Interface
- `DATA_W`, 8, activation/weight width
- `ACC_W`, 17, partial-sum width
- `CNT_W`, 16, beat-counter width
- `MAX_K`, 7, largest legal kernel size
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `start` in 1: job request, sampled only in IDLE
- `cfg_k` in 4: kernel size K, legal range 1..MAX_K
- `cfg_rows` in CNT_W: activation rows R
- `busy` out 1: high from LOAD_W through DONE
- `done` out 1: one-cycle completion pulse
- `err` out 1: config error, sticky until next accepted start
- `w_valid` in 1 / `w_data` in DATA_W / `w_ready` out 1: weight stream
- `a_valid` in 1 / `a_data` in DATA_W / `a_ready` out 1: activation stream
- `workstate` out 1: PE array enable
- `array_w` out DATA_W / `array_w_vld` out 1: weight to array
- `array_a` out DATA_W / `array_a_vld` out 1: activation to array
- `array_psum` in ACC_W / `array_psum_vld` in 1: array result
- `res_data` out ACC_W / `res_valid` out 1: forwarded result
- `phase` out 3: current state encoding

## Operation
- **States:** IDLE=0, LOAD_W=1, COMPUTE=2, DRAIN=3, DONE=4.
- **IDLE, start:** on `start`, latch K, R, KK=K*K (8 bits) and RK=R*K.
  - Config is invalid if K==0, K>MAX_K, or RK overflows CNT_W.
  - Invalid config: set `err`=1, pulse `done` for one cycle, stay in IDLE, `busy` stays 0.
  - Valid config: clear `err`, go to LOAD_W.
- **LOAD_W:** `w_ready`=1.
  - Each `w_valid&&w_ready` beat registers `w_data` into `array_w` with `array_w_vld`=1 the next cycle; otherwise `array_w_vld`=0.
  - After KK beats, go to COMPUTE, or to DRAIN if R==0.
- **COMPUTE:** `a_ready`=1.
  - Each handshake beat registers to `array_a`/`array_a_vld`. A stalled cycle gives `array_a_vld`=0 and the counter holds.
  - After RK beats, go to DRAIN.
- **DRAIN:** counts exactly 2K-1 cycles with no flow control, then goes to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **workstate:** high in LOAD_W, COMPUTE and DRAIN.
- **Results:** during COMPUTE and DRAIN, `res_valid`/`res_data` are the registered `array_psum_vld`/`array_psum`. `array_psum_vld` is ignored in all other states.
- **Start while busy:** ignored.
- **Config inputs while busy:** changes are ignored; latched values are used.
- **Reset mid-job:** immediate return to IDLE and the in-flight job is discarded.
- **Reset values:** every output is 0.

## Timing
- `busy` rises the cycle after `start` is sampled.
- Ready signals are combinational from state only; they never depend on `valid`.
- Array outputs lag the accepted handshake by exactly 1 cycle.
- Stall-free job length, start edge to `done` pulse: 1 + KK + RK + (2K-1) + 1 cycles.
- The final beat of each phase and the state transition occur on the same edge; the next phase's ready is asserted the following cycle.
- Result latency is 1 cycle.

## Configuration
- **`PE_SEQ_TSV_LOAD_EN` defined:**
  - Adds ports `tsv_w_valid` in 1, `tsv_w_data` in DATA_W, `tsv_w_ready` out 1.
  - LOAD_W takes weights from the TSV port.
  - `w_ready` is tied to 0.
- **Undefined:** the TSV ports are absent and weights come from `w_*`.

## Structure
- **Package `pe_seq_pkg`:** state enum, `PHASE_*` encodings, and the default width constants.
- **Sub-module `pe_seq_beat_counter`:** loadable down-counter with decrement enable and zero flag. One instance is shared across LOAD_W, COMPUTE and DRAIN, reloaded at each transition.

## Test plan
- **Nominal:** K=3, R=4, no stalls.
  - 9 `array_w_vld` pulses, then 12 `array_a_vld` pulses.
  - Drain lasts 5 cycles.
  - `done` arrives 28 cycles after the start edge.
- **Weight stalls:** K=3, `w_valid` toggled every other cycle.
  - Exactly 9 `array_w_vld` pulses, each 1 cycle after a handshake.
  - Done is delayed by 8 cycles.
- **Bad config:** `cfg_k`=0 or `cfg_k`=8.
  - `err`=1 and a `done` pulse the next cycle; `busy` never rises.
  - A following valid start clears `err`.
- **Reset mid-job:** `reset` pulsed mid-COMPUTE.
  - All outputs go to 0 immediately and `phase`=0.
  - A new job (K=2, R=1) completes in 1+4+2+3+1 = 11 cycles.
- **Corner cases:** R=0 with K=2.
  - LOAD_W goes straight to DRAIN; `array_a_vld` never asserts.
  - A `start` pulsed during DRAIN is ignored.
- **With `PE_SEQ_TSV_LOAD_EN`:** K=2.
  - Weights are accepted only from `tsv_w_*`.
  - `w_ready` stays 0; `array_w` matches the TSV data in order.
